mult_int7b_accum: RTL and testbench



---
 rtl/mult_int7b_pkg.sv | 15 +
 rtl/sat_add.sv | 36 +++
 rtl/mult_int7b_accum.sv | 98 +++++++++
 tb/tb_mult_int7b_accum.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mult_int7b_pkg.sv
// Shared types and constants for the 7-bit multiplier MAC datapath.
package mult_int7b_pkg;

  localparam int IN_WIDTH_DEF  = 14;
  localparam int ACC_WIDTH_DEF = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX = 16'sh7FFF;
  localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN = 16'sh8000;

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with clamp to the accumulator range.
// The term is sign-extended and the sum formed one bit wider, so overflow never wraps.
module sat_add #(
  parameter int IN_WIDTH  = 14,
  parameter int ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic signed [IN_WIDTH-1:0]  term_i,
  output logic signed [ACC_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  localparam int SW = ACC_WIDTH + 1;

  logic signed [SW-1:0]        wide_s;
  logic signed [ACC_WIDTH-1:0] max_s;
  logic signed [ACC_WIDTH-1:0] min_s;

  assign wide_s = {acc_i[ACC_WIDTH-1], acc_i}
                + {{(SW-IN_WIDTH){term_i[IN_WIDTH-1]}}, term_i};
  assign max_s  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign min_s  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Top two bits disagree exactly when the true sum left the ACC_WIDTH range.
  always_comb begin
    sum_o = wide_s[ACC_WIDTH-1:0];
    ovf_o = 1'b0;
    if (wide_s[SW-1] != wide_s[SW-2]) begin
      ovf_o = 1'b1;
      sum_o = wide_s[SW-1] ? min_s : max_s;
    end else begin
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/mult_int7b_accum.sv
// Saturating accumulator: sums NUM_TERMS products per window and presents
// one result word over a valid/ready handshake before starting the next window.
module mult_int7b_accum
  import mult_int7b_pkg::*;
#(
  parameter  int IN_WIDTH  = IN_WIDTH_DEF,
  parameter  int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter  int NUM_TERMS = 16,
  localparam int CNT_WIDTH = $clog2(NUM_TERMS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_ovf
);

  state_e                      state_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic        [CNT_WIDTH-1:0] cnt_q;
  logic                        sticky_q;
  logic                        out_valid_q;
  logic signed [ACC_WIDTH-1:0] out_data_q;
  logic                        out_ovf_q;

  logic signed [ACC_WIDTH-1:0] sum_d;
  logic                        ovf_d;

  sat_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc_i  (acc_q),
    .term_i (in_data),
    .sum_o  (sum_d),
    .ovf_o  (ovf_d)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Window FSM: in ACCUM in_ready is high, so in_valid alone means accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == CNT_WIDTH'(NUM_TERMS - 1)) begin
              out_data_q  <= sum_d;
              out_ovf_q   <= sticky_q | ovf_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              sticky_q    <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q    <= sum_d;
              cnt_q    <= cnt_q + CNT_WIDTH'(1);
              sticky_q <= sticky_q | ovf_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_int7b_accum.sv
// Directed bench for mult_int7b_accum: hand-computed windows covering
// saturation, back-pressure, clear and asynchronous reset.
module tb_mult_int7b_accum;

  localparam int IN_W  = 14;
  localparam int ACC_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mult_int7b_accum #(
    .IN_WIDTH  (IN_W),
    .ACC_WIDTH (ACC_W),
    .NUM_TERMS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Presents n terms of value v back to back; returns at the negedge after the last accept.
  task automatic send(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = IN_W'(v);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_ovf", int'(out_ovf), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 16 x 100, downstream always ready
    send(15, 100);
    check_eq("t1_no_early_valid", int'(out_valid), 0);
    send(1, 100);
    check_eq("t1_out_valid", int'(out_valid), 1);
    check_eq("t1_in_ready_low", int'(in_ready), 0);
    check_eq("t1_out_data", int'(out_data), 1600);
    check_eq("t1_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    check_eq("t1_valid_drop", int'(out_valid), 0);
    check_eq("t1_in_ready_back", int'(in_ready), 1);

    // 16 x 4096: clamps on the 8th term
    send(7, 4096);
    check_eq("t2_acc7", int'(dut.acc_q), 28672);
    send(1, 4096);
    check_eq("t2_acc8", int'(dut.acc_q), 32767);
    send(8, 4096);
    check_eq("t2_out_data", int'(out_data), 32767);
    check_eq("t2_out_ovf", int'(out_ovf), 1);
    @(negedge clk);

    // 9 x -4032 clamps at -32768, then 7 x +4032 climbs from the clamp
    send(9, -4032);
    check_eq("t3_acc_clamp", int'(dut.acc_q), -32768);
    send(7, 4032);
    check_eq("t3_out_data", int'(out_data), -4544);
    check_eq("t3_out_ovf", int'(out_ovf), 1);
    @(negedge clk);

    // back-pressure in HOLD with in_valid held high
    out_ready = 1'b0;
    send(16, 1);
    in_valid = 1'b1; in_data = IN_W'(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_hold_in_ready", int'(in_ready), 0);
      check_eq("t4_hold_valid", int'(out_valid), 1);
      check_eq("t4_hold_data", int'(out_data), 16);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_released", int'(out_valid), 0);
    send(16, 2);
    check_eq("t4_next_window", int'(out_data), 32);
    check_eq("t4_next_ovf", int'(out_ovf), 0);
    @(negedge clk);

    // clr with a simultaneous term drops it
    send(5, 10);
    in_valid = 1'b1; in_data = IN_W'(10); clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check_eq("t5_clr_cnt", int'(dut.cnt_q), 0);
    send(16, 1);
    check_eq("t5_after_clr", int'(out_data), 16);
    @(negedge clk);

    // clr in HOLD discards the pending result
    out_ready = 1'b0;
    send(16, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("t5_clr_hold_valid", int'(out_valid), 0);
    check_eq("t5_clr_hold_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // asynchronous reset mid-window
    send(3, 7);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_mid_data", int'(out_data), 0);
    check_eq("t6_rst_mid_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(16, 2);
    check_eq("t6_post_rst_sum", int'(out_data), 32);
    @(negedge clk);

    // asynchronous reset in HOLD
    out_ready = 1'b0;
    send(16, 3);
    check_eq("t6_hold_data", int'(out_data), 48);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_hold_valid", int'(out_valid), 0);
    check_eq("t6_rst_hold_ready", int'(in_ready), 1);
    check_eq("t6_rst_hold_data", int'(out_data), 0);
    check_eq("t6_rst_hold_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16, 5);
    check_eq("t6_post_rst2_sum", int'(out_data), 80);
    check_eq("t6_post_rst2_valid", int'(out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
